sonar_array_wb_hub: RTL and testbench

//  Wishbone slave hub for an array of N_CH SonarOnChip channels at 0x3000_0000. Decodes
//  the address space into hub registers and per-channel windows, issues single-channel

---
 rtl/sonar_array_wb_hub.sv | 200 ++++++++++++++++++++
 tb/tb_sonar_array_wb_hub.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sonar_array_wb_hub.sv
// Wishbone slave hub for an array of sonar channels: hub registers, per-channel
// request/ack forwarding with a watchdog, PCM clock-enable prescaler and a
// masked sticky compare-status interrupt.
module sonar_array_wb_hub #(
   parameter int unsigned N_CH    = 2,
   parameter int unsigned DW      = 16,
   parameter int unsigned TIMEOUT = 15,
   parameter int unsigned PRE_RST = 49
) (
   input  logic               wb_clk_i,
   input  logic               wb_rst_i,
   input  logic               wbs_cyc_i,
   input  logic               wbs_stb_i,
   input  logic               wbs_we_i,
   input  logic [3:0]         wbs_sel_i,
   input  logic [31:0]        wbs_adr_i,
   input  logic [31:0]        wbs_dat_i,
   output logic               wbs_ack_o,
   output logic [31:0]        wbs_dat_o,
   output logic [N_CH-1:0]    ch_valid_o,
   output logic [3:0]         ch_adr_o,
   output logic [DW-1:0]      ch_dat_o,
   output logic               ch_strb_o,
   input  logic [N_CH-1:0]    ch_ack_i,
   input  logic [N_CH*DW-1:0] ch_dat_i,
   input  logic [N_CH-1:0]    cmp_i,
   output logic               ce_pcm,
   output logic               irq_o
);

   localparam int unsigned KW       = 5;
   localparam logic [7:0]  TO_LAST  = 8'(TIMEOUT - 1);
   localparam logic [7:0]  PRE_INIT = 8'(PRE_RST);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK, S_GAP} state_t;

   state_t            state;
   logic [KW-1:0]     ch_idx;
   logic [7:0]        wd_cnt;
   logic [N_CH-1:0]   status;
   logic [N_CH-1:0]   irq_mask;
   logic [7:0]        prescaler;
   logic [7:0]        pcm_cnt;
   logic              tostat_flag;
   logic [7:0]        tostat_ch;

   logic [8:0]        w;
   logic [KW-1:0]     blk;
   logic [KW-1:0]     k_dec;
   logic              hit;
   logic              is_ch;
   logic              reg_wr;
   logic [N_CH-1:0]   status_clr;
   logic [31:0]       rd_val;
   logic              cur_ack;
   logic [DW-1:0]     cur_dat;
   logic [7:0]        pcm_next;
   logic              unused_bits;

   assign unused_bits = &{1'b0, wbs_sel_i[3:1], wbs_adr_i[27:11], wbs_adr_i[1:0], wbs_dat_i};

   // Address decode: hub register window below word 16, channel windows above
   always_comb begin
      w          = wbs_adr_i[10:2];
      blk        = w[8:4];
      k_dec      = blk - 5'd1;
      hit        = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:28] == 4'h3);
      is_ch      = (blk != '0) && (32'(k_dec) < N_CH);
      reg_wr     = (state == S_IDLE) & hit & ~is_ch & (blk == '0) & wbs_we_i & wbs_sel_i[0];
      status_clr = (reg_wr && w[3:0] == 4'd0) ? wbs_dat_i[N_CH-1:0] : '0;
   end

   // Hub register read mux; unmapped and out-of-range channel words read 0
   always_comb begin
      rd_val = '0;
      if (blk == '0) begin
         case (w[3:0])
            4'd0:    rd_val = 32'(status);
            4'd1:    rd_val = 32'(prescaler);
            4'd2:    rd_val = 32'(irq_mask);
            4'd3:    rd_val = {tostat_flag, 23'd0, tostat_ch};
            default: rd_val = '0;
         endcase
      end
   end

   // Ack and read data of the channel currently being accessed
   always_comb begin
      cur_ack = 1'b0;
      cur_dat = '0;
      for (int i = 0; i < int'(N_CH); i++) begin
         if (ch_idx == KW'(i)) begin
            cur_ack = ch_ack_i[i];
            cur_dat = ch_dat_i[i*DW +: DW];
         end
      end
   end

   // Access FSM: register ops, channel requests, watchdog, ack and gap cycle
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state       <= S_IDLE;
         wbs_ack_o   <= 1'b0;
         wbs_dat_o   <= '0;
         ch_valid_o  <= '0;
         ch_adr_o    <= '0;
         ch_dat_o    <= '0;
         ch_strb_o   <= 1'b0;
         ch_idx      <= '0;
         wd_cnt      <= '0;
         tostat_flag <= 1'b0;
         tostat_ch   <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (hit) begin
                  if (is_ch) begin
                     state      <= S_WAIT;
                     ch_idx     <= k_dec;
                     ch_valid_o <= N_CH'(1) << k_dec;
                     ch_adr_o   <= w[3:0];
                     ch_dat_o   <= {wbs_dat_i[31], wbs_dat_i[DW-2:0]};
                     ch_strb_o  <= wbs_we_i & wbs_sel_i[0];
                     wd_cnt     <= '0;
                  end else begin
                     state     <= S_ACK;
                     wbs_ack_o <= 1'b1;
                     wbs_dat_o <= rd_val;
                     if (reg_wr && w[3:0] == 4'd3 && wbs_dat_i[31])
                        tostat_flag <= 1'b0;
                  end
               end
            end
            S_WAIT: begin
               if (!wbs_cyc_i) begin
                  state      <= S_IDLE;
                  ch_valid_o <= '0;
                  ch_strb_o  <= 1'b0;
               end else if (cur_ack) begin
                  state      <= S_ACK;
                  wbs_ack_o  <= 1'b1;
                  wbs_dat_o  <= 32'($signed(cur_dat));
                  ch_valid_o <= '0;
                  ch_strb_o  <= 1'b0;
               end else if (wd_cnt == TO_LAST) begin
                  state       <= S_ACK;
                  wbs_ack_o   <= 1'b1;
                  wbs_dat_o   <= 32'hDEAD_BEEF;
                  ch_valid_o  <= '0;
                  ch_strb_o   <= 1'b0;
                  tostat_flag <= 1'b1;
                  tostat_ch   <= 8'(ch_idx);
               end else begin
                  wd_cnt <= wd_cnt + 8'd1;
               end
            end
            S_ACK: begin
               state     <= S_GAP;
               wbs_ack_o <= 1'b0;
               wbs_dat_o <= '0;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   // Configuration registers and sticky status; a set wins over a same-cycle clear
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         status    <= '0;
         irq_mask  <= '0;
         prescaler <= PRE_INIT;
         irq_o     <= 1'b0;
      end else begin
         status <= (status & ~status_clr) | cmp_i;
         irq_o  <= |(status & irq_mask);
         if (reg_wr && w[3:0] == 4'd1) prescaler <= wbs_dat_i[7:0];
         if (reg_wr && w[3:0] == 4'd2) irq_mask  <= wbs_dat_i[N_CH-1:0];
      end
   end

   // PCM down-counter; a new prescaler value is picked up only on reload
   always_comb begin
      pcm_next = (pcm_cnt == 8'd0) ? prescaler : pcm_cnt - 8'd1;
   end

   // PCM clock enable asserted while the counter sits at zero
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         pcm_cnt <= '0;
         ce_pcm  <= 1'b0;
      end else begin
         pcm_cnt <= pcm_next;
         ce_pcm  <= (pcm_next == 8'd0);
      end
   end

endmodule

// File: tb/tb_sonar_array_wb_hub.sv
// Directed bench for sonar_array_wb_hub with default parameters.
module tb_sonar_array_wb_hub;

   logic        clk = 1'b0;
   logic        rst;
   logic        cyc, stb, we;
   logic [3:0]  sel;
   logic [31:0] adr, wdat;
   logic        ack;
   logic [31:0] rdat;
   logic [1:0]  ch_valid;
   logic [3:0]  ch_adr;
   logic [15:0] ch_dat;
   logic        ch_strb;
   logic [1:0]  ch_ack;
   logic [31:0] ch_dat_in;
   logic [1:0]  cmp;
   logic        ce_pcm;
   logic        irq;

   int checks   = 0;
   int failures = 0;
   int n;
   logic        got_ack;
   logic [31:0] got_dat;
   logic [1:0]  got_valid;

   sonar_array_wb_hub dut (
      .wb_clk_i   (clk),
      .wb_rst_i   (rst),
      .wbs_cyc_i  (cyc),
      .wbs_stb_i  (stb),
      .wbs_we_i   (we),
      .wbs_sel_i  (sel),
      .wbs_adr_i  (adr),
      .wbs_dat_i  (wdat),
      .wbs_ack_o  (ack),
      .wbs_dat_o  (rdat),
      .ch_valid_o (ch_valid),
      .ch_adr_o   (ch_adr),
      .ch_dat_o   (ch_dat),
      .ch_strb_o  (ch_strb),
      .ch_ack_i   (ch_ack),
      .ch_dat_i   (ch_dat_in),
      .cmp_i      (cmp),
      .ce_pcm     (ce_pcm),
      .irq_o      (irq)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL tb_timeout observed=hang expected=finish");
      $fatal(1, "bench time limit");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic bus_start(input logic [31:0] a, input logic w_en, input logic [31:0] d);
      cyc = 1'b1; stb = 1'b1; we = w_en; adr = a; wdat = d;
   endtask

   task automatic bus_end();
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
   endtask

   // One single-cycle hub access, leaving the hub back in IDLE
   task automatic hub_access(input logic [31:0] a, input logic w_en, input logic [31:0] d);
      bus_start(a, w_en, d);
      tick();
      got_ack   = ack;
      got_dat   = rdat;
      got_valid = ch_valid;
      bus_end();
      tick();
      tick();
   endtask

   initial begin
      rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'hF;
      adr = '0; wdat = '0; ch_ack = '0; ch_dat_in = '0; cmp = '0;
      repeat (3) tick();
      chk("rst_ack", 32'(ack), 32'd0);
      chk("rst_dat", rdat, 32'd0);
      chk("rst_valid", 32'(ch_valid), 32'd0);
      chk("rst_strb", 32'(ch_strb), 32'd0);
      chk("rst_ce", 32'(ce_pcm), 32'd0);
      chk("rst_irq", 32'(irq), 32'd0);
      rst = 1'b0;

      // ce_pcm period with reset prescaler
      n = 0;
      while (ce_pcm !== 1'b1 && n < 200) begin tick(); n++; end
      chk("ce_first", 32'(n), 32'd50);
      tick(); n = 1;
      while (ce_pcm !== 1'b1 && n < 200) begin tick(); n++; end
      chk("ce_period_49", 32'(n), 32'd50);

      // Prescaler read: ack one cycle after stb, single-cycle ack
      bus_start(32'h3000_0004, 1'b0, 32'd0);
      chk("presc_ack_pre", 32'(ack), 32'd0);
      tick();
      chk("presc_ack", 32'(ack), 32'd1);
      chk("presc_rd", rdat, 32'd49);
      bus_end();
      tick();
      chk("ack_one_cycle", 32'(ack), 32'd0);
      tick();

      // Prescaler write 4 takes effect at next reload
      hub_access(32'h3000_0004, 1'b1, 32'h0000_0004);
      chk("presc_wr_ack", 32'(got_ack), 32'd1);
      n = 0;
      while (ce_pcm !== 1'b1 && n < 100) begin tick(); n++; end
      chk("ce_after_wr", 32'(ce_pcm), 32'd1);
      tick(); n = 1;
      while (ce_pcm !== 1'b1 && n < 100) begin tick(); n++; end
      chk("ce_period_4", 32'(n), 32'd5);
      hub_access(32'h3000_0004, 1'b0, 32'd0);
      chk("presc_rd4", got_dat, 32'd4);

      // Prescaler 0 holds ce_pcm high
      hub_access(32'h3000_0004, 1'b1, 32'd0);
      n = 0;
      while (ce_pcm !== 1'b1 && n < 20) begin tick(); n++; end
      tick();
      chk("ce_hold_a", 32'(ce_pcm), 32'd1);
      tick();
      chk("ce_hold_b", 32'(ce_pcm), 32'd1);

      // Reserved word, foreign address, out-of-range channel
      hub_access(32'h3000_0014, 1'b0, 32'd0);
      chk("rsvd_ack", 32'(got_ack), 32'd1);
      chk("rsvd_dat", got_dat, 32'd0);
      hub_access(32'h2000_0004, 1'b0, 32'd0);
      chk("foreign_noack", 32'(got_ack), 32'd0);
      hub_access(32'h3000_00C0, 1'b0, 32'd0);
      chk("oor_ack", 32'(got_ack), 32'd1);
      chk("oor_dat", got_dat, 32'd0);
      chk("oor_valid", 32'(got_valid), 32'd0);

      // Channel 1 read, ack after 3 cycles; stray ack on channel 0 ignored
      bus_start(32'h3000_0084, 1'b0, 32'd0);
      tick();
      chk("ch1_valid", 32'(ch_valid), 32'h2);
      chk("ch1_adr", 32'(ch_adr), 32'h1);
      chk("ch1_strb", 32'(ch_strb), 32'd0);
      ch_ack = 2'b01; ch_dat_in = 32'h0000_5555;
      tick();
      chk("ch1_other_ack", 32'(ack), 32'd0);
      chk("ch1_hold", 32'(ch_valid), 32'h2);
      ch_ack = 2'b00;
      tick();
      ch_ack = 2'b10; ch_dat_in = 32'h8001_5555;
      tick();
      chk("ch1_ack", 32'(ack), 32'd1);
      chk("ch1_dat", rdat, 32'hFFFF_8001);
      chk("ch1_valid_drop", 32'(ch_valid), 32'd0);
      ch_ack = 2'b00; ch_dat_in = '0;
      bus_end();
      tick();
      chk("ch1_ack_drop", 32'(ack), 32'd0);
      tick();

      // Channel 0 never acks: watchdog
      bus_start(32'h3000_0040, 1'b0, 32'd0);
      tick();
      chk("to0_valid", 32'(ch_valid), 32'h1);
      repeat (14) tick();
      chk("to0_early", 32'(ack), 32'd0);
      tick();
      chk("to0_ack", 32'(ack), 32'd1);
      chk("to0_dat", rdat, 32'hDEAD_BEEF);
      chk("to0_valid_drop", 32'(ch_valid), 32'd0);
      bus_end();
      tick(); tick();
      hub_access(32'h3000_000C, 1'b0, 32'd0);
      chk("tostat0", got_dat, 32'h8000_0000);
      hub_access(32'h3000_000C, 1'b1, 32'h8000_0000);
      hub_access(32'h3000_000C, 1'b0, 32'd0);
      chk("tostat_clr", got_dat, 32'd0);

      // Channel 1 write, times out
      bus_start(32'h3000_0088, 1'b1, 32'h8000_00AB);
      tick();
      chk("wr1_valid", 32'(ch_valid), 32'h2);
      chk("wr1_adr", 32'(ch_adr), 32'h2);
      chk("wr1_dat", 32'(ch_dat), 32'h80AB);
      chk("wr1_strb", 32'(ch_strb), 32'd1);
      repeat (15) tick();
      chk("wr1_to_ack", 32'(ack), 32'd1);
      bus_end();
      tick(); tick();
      hub_access(32'h3000_000C, 1'b0, 32'd0);
      chk("tostat1", got_dat, 32'h8000_0001);

      // Interrupt path
      hub_access(32'h3000_0008, 1'b1, 32'd1);
      cmp = 2'b01;
      tick();
      cmp = 2'b00;
      chk("irq_lag", 32'(irq), 32'd0);
      tick();
      chk("irq_set", 32'(irq), 32'd1);
      hub_access(32'h3000_0000, 1'b0, 32'd0);
      chk("status_rd", got_dat, 32'd1);
      cmp = 2'b01;
      hub_access(32'h3000_0000, 1'b1, 32'd1);
      cmp = 2'b00;
      hub_access(32'h3000_0000, 1'b0, 32'd0);
      chk("status_set_wins", got_dat, 32'd1);
      hub_access(32'h3000_0000, 1'b1, 32'd1);
      hub_access(32'h3000_0000, 1'b0, 32'd0);
      chk("status_clr", got_dat, 32'd0);
      chk("irq_clr", 32'(irq), 32'd0);
      cmp = 2'b10;
      tick();
      cmp = 2'b00;
      tick(); tick();
      chk("irq_masked", 32'(irq), 32'd0);
      hub_access(32'h3000_0000, 1'b0, 32'd0);
      chk("status_bit1", got_dat, 32'd2);

      // Held stb: gap cycle enforces one access per 3 cycles
      bus_start(32'h3000_0008, 1'b0, 32'd0);
      tick();
      chk("b2b_ack0", 32'(ack), 32'd1);
      chk("b2b_mask", rdat, 32'd1);
      tick();
      chk("b2b_ack1", 32'(ack), 32'd0);
      tick();
      chk("b2b_gap", 32'(ack), 32'd0);
      tick();
      chk("b2b_ack3", 32'(ack), 32'd1);
      bus_end();
      tick(); tick();

      // Master drops cyc during WAIT
      bus_start(32'h3000_0084, 1'b0, 32'd0);
      tick();
      chk("abort_valid", 32'(ch_valid), 32'h2);
      bus_end();
      tick();
      chk("abort_valid_drop", 32'(ch_valid), 32'd0);
      chk("abort_noack", 32'(ack), 32'd0);
      tick();
      chk("abort_noack2", 32'(ack), 32'd0);

      // Reset during WAIT, then a clean access
      bus_start(32'h3000_0040, 1'b0, 32'd0);
      tick(); tick();
      rst = 1'b1;
      tick();
      chk("rstw_noack", 32'(ack), 32'd0);
      chk("rstw_valid", 32'(ch_valid), 32'd0);
      rst = 1'b0;
      bus_end();
      tick();
      hub_access(32'h3000_0004, 1'b0, 32'd0);
      chk("rstw_presc", got_dat, 32'd49);
      bus_start(32'h3000_0084, 1'b0, 32'd0);
      tick();
      chk("clean_valid", 32'(ch_valid), 32'h2);
      ch_ack = 2'b10; ch_dat_in = 32'h0042_0000;
      tick();
      chk("clean_ack", 32'(ack), 32'd1);
      chk("clean_dat", rdat, 32'h0000_0042);
      ch_ack = 2'b00; ch_dat_in = '0;
      bus_end();
      tick(); tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
